// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry, FSM states
// and PC field extraction helpers.
package icache_pkg;

    localparam int unsigned INDEX_W = 5;
    localparam int unsigned WORD_W  = 2;
    localparam int unsigned OFF_W   = 2 + WORD_W;
    localparam int unsigned TAG_W   = 32 - OFF_W - INDEX_W;
    localparam int unsigned SETS    = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [WORD_W-1:0] pc_word(input logic [31:0] pc);
        return pc[2 +: WORD_W];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] pc);
        return {pc[31:OFF_W], OFF_W'(0)};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and fill-side signals of the instruction cache; slave is the cache,
// master is the ifetch/memctrl side.
interface icache_if;

    logic        to_icache;
    logic [31:0] pc_to_icache;
    logic        have_result;
    logic [31:0] inst_from_icache;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport slave (
        input  to_icache, pc_to_icache, mem_valid, mem_data,
        output have_result, inst_from_icache, mem_req, mem_addr
    );

    modport master (
        output to_icache, pc_to_icache, mem_valid, mem_data,
        input  have_result, inst_from_icache, mem_req, mem_addr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache returning 32 bits at a halfword-aligned PC,
// filling one or two whole lines (line-straddling fetch) from the memory controller.
module icache
    import icache_pkg::*;
(
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    icache_if.slave bus
);

    state_t             state, state_d;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags [SETS];
    logic [31:0]        data [SETS][WORDS];

    logic [31:0]        req_pc, req_pc_d;
    logic [WORD_W-1:0]  cnt, cnt_d;
    logic [15:0]        lo_hold, lo_hold_d;
    logic               lo_held, lo_held_d;
    logic               have_result_q, have_result_d;
    logic [31:0]        inst_q, inst_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic [31:0]        hi_pc;
    logic [INDEX_W-1:0] lo_idx, hi_idx, fill_idx;
    logic [WORD_W-1:0]  lo_wrd;
    logic               lo_hit, hi_hit, lo_ok, straddle;
    logic               fill_we, fill_last;
    logic [31:0]        lo_word, next_word, hi_word0, assembled;
    logic [15:0]        lo_upper;

    assign hi_pc     = req_pc + 32'd2;
    assign lo_idx    = pc_index(req_pc);
    assign hi_idx    = pc_index(hi_pc);
    assign lo_wrd    = pc_word(req_pc);
    assign fill_idx  = pc_index(mem_addr_q);
    assign lo_hit    = valid[lo_idx] && (tags[lo_idx] == pc_tag(req_pc));
    assign hi_hit    = valid[hi_idx] && (tags[hi_idx] == pc_tag(hi_pc));
    assign straddle  = req_pc[1] && (&lo_wrd);
    // Once the lo half is captured before a hi fill, lo no longer needs to be resident.
    assign lo_ok     = lo_hit || lo_held;
    assign fill_we   = (state == FILL) && bus.mem_valid;
    assign fill_last = &cnt;

    assign lo_word   = data[lo_idx][lo_wrd];
    assign next_word = data[lo_idx][lo_wrd + WORD_W'(1)];
    assign hi_word0  = data[hi_idx][0];
    assign lo_upper  = lo_held ? lo_hold : lo_word[31:16];

    always_comb begin
        assembled = lo_word;
        if (straddle)       assembled = {hi_word0[15:0], lo_upper};
        else if (req_pc[1]) assembled = {next_word[15:0], lo_word[31:16]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state;
        req_pc_d      = req_pc;
        cnt_d         = cnt;
        lo_hold_d     = lo_hold;
        lo_held_d     = lo_held;
        have_result_d = 1'b0;
        inst_d        = inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        unique case (state)
            IDLE: begin
                if (bus.to_icache) begin
                    req_pc_d  = bus.pc_to_icache;
                    lo_held_d = 1'b0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!lo_ok) begin
                    mem_addr_d = line_base(req_pc);
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = FILL;
                end else if (straddle && !hi_hit) begin
                    mem_addr_d = line_base(hi_pc);
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                    lo_hold_d  = lo_upper;
                    lo_held_d  = 1'b1;
                    state_d    = FILL;
                end else begin
                    have_result_d = 1'b1;
                    inst_d        = assembled;
                    state_d       = IDLE;
                end
            end
            FILL: begin
                if (bus.mem_valid) begin
                    cnt_d = cnt + WORD_W'(1);
                    if (fill_last) begin
                        mem_req_d = 1'b0;
                        state_d   = LOOKUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      state <= IDLE;
        else if (rdy_in) state <= state_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid         <= '0;
            req_pc        <= '0;
            cnt           <= '0;
            lo_hold       <= '0;
            lo_held       <= 1'b0;
            have_result_q <= 1'b0;
            inst_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else if (rdy_in) begin
            if (fill_we && fill_last) valid[fill_idx] <= 1'b1;
            req_pc        <= req_pc_d;
            cnt           <= cnt_d;
            lo_hold       <= lo_hold_d;
            lo_held       <= lo_held_d;
            have_result_q <= have_result_d;
            inst_q        <= inst_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    // Tag and data storage carry no reset so they can map onto SRAM later
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            data[fill_idx][cnt] <= bus.mem_data;
            if (fill_last) tags[fill_idx] <= pc_tag(mem_addr_q);
        end
    end

    assign bus.have_result      = have_result_q;
    assign bus.inst_from_icache = inst_q;
    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fetches against a small memory model with a memctrl
// responder that starts beats one cycle after seeing mem_req.
module tb_icache;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus();

    icache dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int unsigned];
    logic [31:0] fill_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hF00D, a[15:0]};
    endfunction

    // One fetch: request, serve fills, then check data, latency, fill count and address.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int exp_fills,
                         input logic [31:0] exp_addr0, input int pause_beat);
        int          cycles;
        int          beat;
        int          exp_lat;
        bit          started;
        bit          got;
        bit          paused;
        bit          drop_pending;
        logic [31:0] addr_hold;
        exp_lat = 2 + 6 * exp_fills + ((pause_beat >= 0) ? 3 : 0);
        fill_log.delete();
        cycles = 0; beat = 0; started = 0; got = 0; paused = 0; drop_pending = 0;
        @(negedge clk);
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = pc;
        while (!got && cycles < 200) begin
            @(negedge clk);
            cycles++;
            bus.to_icache = 1'b0;
            bus.mem_valid = 1'b0;
            if (drop_pending) begin
                check_eq("req_drop", 32'(bus.mem_req), 32'd0);
                drop_pending = 0;
            end
            if (bus.have_result) begin
                got = 1;
                check_eq("inst", bus.inst_from_icache, exp);
            end else if (bus.mem_req) begin
                if (!started) begin
                    started = 1;
                    fill_log.push_back(bus.mem_addr);
                end else begin
                    if (beat == pause_beat && !paused) begin
                        paused        = 1;
                        addr_hold     = bus.mem_addr;
                        rdy           = 1'b0;
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = 32'hDEADBEEF;
                        repeat (3) begin
                            @(negedge clk);
                            cycles++;
                            check_eq("pause_req", 32'(bus.mem_req), 32'd1);
                            check_eq("pause_addr", bus.mem_addr, addr_hold);
                        end
                        rdy = 1'b1;
                    end
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = mem_rd(bus.mem_addr + 32'(4 * beat));
                    beat++;
                    if (beat == 4) begin
                        beat = 0;
                        started = 0;
                        drop_pending = 1;
                    end
                end
            end
        end
        check_eq("done", 32'(got), 32'd1);
        check_eq("latency", 32'(cycles), 32'(exp_lat));
        check_eq("fills", 32'(fill_log.size()), 32'(exp_fills));
        if (fill_log.size() > 0) check_eq("fill_addr0", fill_log[0], exp_addr0);
        @(negedge clk);
        check_eq("pulse", 32'(bus.have_result), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.to_icache    = 1'b0;
        bus.pc_to_icache = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_data     = '0;
        #1;
        check_eq("rst_have_result", 32'(bus.have_result), 32'd0);
        check_eq("rst_inst", bus.inst_from_icache, 32'd0);
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mem[32'h0] = 32'h11; mem[32'h4] = 32'h22; mem[32'h8] = 32'h33; mem[32'hC] = 32'h44;
        fetch(32'h0000, 32'h00000011, 1, 32'h0, -1);
        fetch(32'h0004, 32'h00000022, 0, 32'h0, -1);
        fetch(32'h0200, 32'hF00D0200, 1, 32'h200, -1);

        mem[32'h4]  = 32'hAAAABBBB;
        mem[32'h8]  = 32'hCCCCDDDD;
        mem[32'hC]  = 32'h12345678;
        mem[32'h10] = 32'h9ABCDEF0;
        fetch(32'h0000, 32'h00000011, 1, 32'h0, -1);
        fetch(32'h0006, 32'hDDDDAAAA, 0, 32'h0, -1);
        fetch(32'h0007, 32'hDDDDAAAA, 0, 32'h0, -1);

        fetch(32'h000E, 32'hDEF01234, 1, 32'h10, -1);
        fetch(32'h0200, 32'hF00D0200, 1, 32'h200, -1);
        fetch(32'h0210, 32'hF00D0210, 1, 32'h210, -1);
        fetch(32'h000E, 32'hDEF01234, 2, 32'h0, -1);
        if (fill_log.size() > 1) check_eq("fill_addr1", fill_log[1], 32'h10);

        fetch(32'h0200, 32'hF00D0200, 1, 32'h200, -1);
        fetch(32'h0008, 32'hCCCCDDDD, 1, 32'h0, 2);

        // Reset in the middle of a fill
        @(negedge clk);
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = 32'h0200;
        @(negedge clk);
        bus.to_icache = 1'b0;
        @(negedge clk);
        check_eq("midfill_req", 32'(bus.mem_req), 32'd1);
        repeat (2) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = 32'h55555555;
            @(negedge clk);
        end
        bus.mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midfill_rst_req", 32'(bus.mem_req), 32'd0);
        check_eq("midfill_rst_hr", 32'(bus.have_result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h0000, 32'h00000011, 1, 32'h0, -1);

        fetch(32'hFFFFFFFE, 32'h0011F00D, 1, 32'hFFFFFFF0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
